// File: rtl/adder_pkg.sv
// adder_pkg: shared mode constants and stage-count helper for the pipelined adder
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Falls back to one stage on an illegal split so the arrays still elaborate;
  // the top reports the bad configuration itself.
  function automatic int stages(input int width, input int slice);
    return (slice < 1 || width < slice) ? 1 : width / slice;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: SLICE-bit combinational ripple add
//   a, b  : slice operands
//   cin   : carry into the slice LSB
//   sum   : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (signed overflow = cmsb ^ cout on the top slice)
module adder_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in can be recovered from it.
  assign cmsb = a[SLICE-1] ^ b[SLICE-1] ^ sum[SLICE-1];

endmodule

// File: rtl/pipelined_adder_n.sv
// pipelined_adder_n: WIDTH-bit adder/subtractor split into SLICE-bit pipeline stages
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid, in_ready      : operand handshake (a, b, c_i, sub)
//   out_valid, out_ready    : result handshake (s, c_o, ovf)
//   sub = 0 : s = a + b + c_i      sub = 1 : s = a - b - c_i (c_o = 1 means no borrow)
module pipelined_adder_n
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_o,
  output logic             ovf
);

  localparam int STAGES = stages(WIDTH, SLICE);

  if (SLICE < 1 || (WIDTH % ((SLICE < 1) ? 1 : SLICE)) != 0) begin : g_bad_cfg
    $error("pipelined_adder_n: WIDTH must be a positive multiple of SLICE");
  end

  logic              advance;
  logic [STAGES-1:0] valid_in, valid_d, valid_q;
  logic [STAGES-1:0] cin_in, carry_d, carry_q;
  logic [STAGES-1:0] slice_cout, slice_cmsb;
  logic              ovf_d, ovf_q;
  logic [WIDTH-1:0]  a_in[STAGES], a_d[STAGES], a_q[STAGES];
  logic [WIDTH-1:0]  b_in[STAGES], b_d[STAGES], b_q[STAGES];
  logic [WIDTH-1:0]  sum_in[STAGES], sum_d[STAGES], sum_q[STAGES];
  logic [SLICE-1:0]  slice_sum[STAGES];

  assign advance   = !valid_q[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign c_o       = carry_q[STAGES-1];
  assign ovf       = ovf_q;

  // Each stage sees full-width operand/sum words: stage k consumes slice k of the
  // operands, writes slice k of the sum and passes the rest along, which gives
  // both the operand skew and the result deskew.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtraction is A + ~B + ~c_i, so B and the carry-in are inverted once here.
      assign a_in[k]     = a;
      assign b_in[k]     = (sub == MODE_SUB) ? ~b : b;
      assign cin_in[k]   = (sub == MODE_SUB) ? ~c_i : c_i;
      assign sum_in[k]   = '0;
      assign valid_in[k] = in_valid;
    end else begin : g_next
      assign a_in[k]     = a_q[k-1];
      assign b_in[k]     = b_q[k-1];
      assign cin_in[k]   = carry_q[k-1];
      assign sum_in[k]   = sum_q[k-1];
      assign valid_in[k] = valid_q[k-1];
    end
    adder_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_in[k][k*SLICE +: SLICE]),
      .b    (b_in[k][k*SLICE +: SLICE]),
      .cin  (cin_in[k]),
      .sum  (slice_sum[k]),
      .cout (slice_cout[k]),
      .cmsb (slice_cmsb[k])
    );
  end

  always_comb begin
    valid_d = advance ? valid_in : valid_q;
    carry_d = advance ? slice_cout : carry_q;
    ovf_d   = advance ? slice_cout[STAGES-1] ^ slice_cmsb[STAGES-1] : ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = advance ? a_in[k] : a_q[k];
      b_d[k]   = advance ? b_in[k] : b_q[k];
      sum_d[k] = advance ? sum_in[k] : sum_q[k];
      if (advance) sum_d[k][k*SLICE +: SLICE] = slice_sum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      sum_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

endmodule
